writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 DATABITWIDTH, default 16: result data width.
REQ-002 TAGBITWIDTH, default 6: instruction tag width.
REQ-003 REGADDRBITWIDTH, default 4: register address width.
REQ-004 FIFODEPTH, default 2: entries per source queue, power of two, at least 2.
REQ-005 Clocking: one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 async_rst  in  1  asynchronous active-high reset.
REQ-008 clk_en  in  1  global clock enable; when low, all state holds.
REQ-009 Src_Valid  in  3  result valid, per source: 0=ALU0, 1=ALU1, 2=Complex/Memory.
REQ-010 Src_Ready  out  3  per-source accept, equal to queue not full.
REQ-011 Src_Data  in  3xDATABITWIDTH  result data per source.
REQ-012 Src_RegAddr  in  3xREGADDRBITWIDTH  destination register per source.
REQ-013 Src_Tag  in  3xTAGBITWIDTH  issuing tag per source.
REQ-014 RegWriteEn  out  1  register file write strobe.
REQ-015 RegWriteAddr  out  REGADDRBITWIDTH  register file write address.
REQ-016 RegWriteData  out  DATABITWIDTH  register file write data.
REQ-017 TagClearValid  out  1  tag release strobe to the issue tracker.
REQ-018 TagClearOut  out  TAGBITWIDTH  tag being released.
REQ-019 IssueCongestionStallOut  out  1  back-pressure to instruction issue.

Function
REQ-020 A source handshake completes on a rising edge with clk_en=1, Src_Valid[i]=1 and Src_Ready[i]=1, and pushes {Data, RegAddr, Tag} into queue i.
REQ-021 Src_Ready[i] is combinational from queue i occupancy: high iff count_i < FIFODEPTH, independent of Src_Valid.
REQ-022 Each cycle, a round-robin arbiter grants one non-empty queue, starting at the priority pointer and moving upward modulo 3.
REQ-023 After a grant to queue i, the priority pointer becomes (i+1) mod 3; with no grant, the pointer holds.
REQ-024 The granted head pops on the same edge that loads the output register; outputs are registered.
REQ-025 Latency: an entry pushed on edge E, and granted immediately, drives outputs during the cycle after edge E+1.
REQ-026 TagClearValid pulses for exactly one cycle per granted entry.
REQ-027 RegWriteEn pulses with TagClearValid, except that it stays 0 when the granted RegWriteAddr is 0 (register 0 discard); the tag is still released.
REQ-028 With no grant, RegWriteEn and TagClearValid are 0; the address, data and tag outputs hold their last values.
REQ-029 A push and a pop on the same queue in the same edge leave count unchanged; data order is strict FIFO per source.
REQ-030 Read and write pointers wrap modulo FIFODEPTH; count has log2(FIFODEPTH)+1 bits.
REQ-031 IssueCongestionStallOut is registered and is 1 in the cycle after any queue count reaches FIFODEPTH-1 or more after the edge update.
REQ-032 When clk_en=0: no push, pop or pointer change occurs; RegWriteEn and TagClearValid are forced to 0 on the next edge.

Reset
REQ-033 async_rst clears all counts, pointers and the priority pointer (to 0), and clears RegWriteEn, TagClearValid and IssueCongestionStallOut; other outputs go to 0.
REQ-034 A reset mid-operation discards all queued entries; no tag from before reset is ever released after reset.

Structure
REQ-035 The source index enum (ALU0, ALU1, COMPLEX) and the source count constant belong in the shared control package.
REQ-036 One sub-module, wb_result_fifo (parameterised width and depth), is instantiated three times; the arbiter and output register are in the top module.

Verification
REQ-037 Single result: ALU0 pushes Data=0x1234, Addr=5, Tag=9 -> two cycles later, a one-cycle write pulse with Addr 5, Data 0x1234, TagClearOut 9.
REQ-038 All three sources push at once with pointer 0 -> grants in order 0, 1, 2 on consecutive cycles; pointer ends at 0.
REQ-039 Hold ALU1 valid with Src_Ready tracked -> after FIFODEPTH accepts without a grant, Src_Ready[1]=0 and the stall is 1; it drops after the pop.
REQ-040 Result with RegAddr=0, Tag=3 -> RegWriteEn stays 0, TagClearValid=1 with TagClearOut=3.
REQ-041 Assert async_rst while two entries are queued -> outputs clear immediately; no TagClearValid pulse follows.
REQ-042 clk_en low for 3 cycles with full queues -> no pulses and counts unchanged; resumes in order when clk_en returns high.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// Shared source indexing for the writeback arbiter.
// Sources are ordered ALU0, ALU1, Complex/Memory; rotation order follows the encoding.
package writeback_arbiter_pkg;

  typedef enum logic [1:0] {
    SRC_ALU0    = 2'd0,
    SRC_ALU1    = 2'd1,
    SRC_COMPLEX = 2'd2
  } srcIdx_e;

  localparam int NUMSOURCES = 3;

  function automatic srcIdx_e nextSrc(input srcIdx_e idx);
    srcIdx_e res;
    case (idx)
      SRC_ALU0:    res = SRC_ALU1;
      SRC_ALU1:    res = SRC_COMPLEX;
      SRC_COMPLEX: res = SRC_ALU0;
      default:     res = SRC_ALU0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/writeback_arbiter_fifo.sv
// Per-source result queue: power-of-two depth, wrapping pointers, and an
// occupancy preview (countNext) so the top can register congestion on the same edge.
module wb_result_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int WIDTH = 26,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     async_rst,
  input  logic                     clk_en,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         headData,
  output logic                     notFull,
  output logic                     notEmpty,
  output logic [$clog2(DEPTH):0]   countNext
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [CNTW-1:0] FULLCNT = CNTW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTRW-1:0]  rdPtr_r;
  logic [PTRW-1:0]  wrPtr_r;
  logic [CNTW-1:0]  count_r;
  logic             doPush_s;
  logic             doPop_s;

  // Occupancy flags, gated handshakes and next occupancy
  always_comb begin
    notFull  = (count_r < FULLCNT);
    notEmpty = (count_r != {CNTW{1'b0}});
    doPush_s = push & notFull & clk_en;
    doPop_s  = pop & notEmpty & clk_en;
    headData = mem_r[rdPtr_r];
    case ({doPush_s, doPop_s})
      2'b10:   countNext = count_r + CNTW'(1);
      2'b01:   countNext = count_r - CNTW'(1);
      default: countNext = count_r;
    endcase
  end

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      rdPtr_r <= {PTRW{1'b0}};
      wrPtr_r <= {PTRW{1'b0}};
      count_r <= {CNTW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      count_r <= countNext;
      if (doPush_s) begin
        mem_r[wrPtr_r] <= pushData;
        wrPtr_r        <= wrPtr_r + PTRW'(1);
      end else begin
        wrPtr_r <= wrPtr_r;
      end
      if (doPop_s) begin
        rdPtr_r <= rdPtr_r + PTRW'(1);
      end else begin
        rdPtr_r <= rdPtr_r;
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: three result queues drained round-robin into a single
// registered register-file write / tag-release port with issue back-pressure.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int DATABITWIDTH    = 16,
  parameter int TAGBITWIDTH     = 6,
  parameter int REGADDRBITWIDTH = 4,
  parameter int FIFODEPTH       = 2
) (
  input  logic                                        clk,
  input  logic                                        async_rst,
  input  logic                                        clk_en,
  input  logic [NUMSOURCES-1:0]                       Src_Valid,
  output logic [NUMSOURCES-1:0]                       Src_Ready,
  input  logic [NUMSOURCES-1:0][DATABITWIDTH-1:0]     Src_Data,
  input  logic [NUMSOURCES-1:0][REGADDRBITWIDTH-1:0]  Src_RegAddr,
  input  logic [NUMSOURCES-1:0][TAGBITWIDTH-1:0]      Src_Tag,
  output logic                                        RegWriteEn,
  output logic [REGADDRBITWIDTH-1:0]                  RegWriteAddr,
  output logic [DATABITWIDTH-1:0]                     RegWriteData,
  output logic                                        TagClearValid,
  output logic [TAGBITWIDTH-1:0]                      TagClearOut,
  output logic                                        IssueCongestionStallOut
);

  localparam int ENTRYW = DATABITWIDTH + REGADDRBITWIDTH + TAGBITWIDTH;
  localparam int CNTW   = $clog2(FIFODEPTH) + 1;
  localparam logic [CNTW-1:0] STALLCNT = CNTW'(FIFODEPTH - 1);

  typedef struct packed {
    logic [DATABITWIDTH-1:0]    data;
    logic [REGADDRBITWIDTH-1:0] regAddr;
    logic [TAGBITWIDTH-1:0]     tag;
  } wbEntry_t;

  wbEntry_t              headEntry_s [NUMSOURCES];
  logic [CNTW-1:0]       cntNext_s   [NUMSOURCES];
  logic [NUMSOURCES-1:0] nonEmpty_s;
  logic [NUMSOURCES-1:0] popVec_s;
  wbEntry_t              grantEntry_s;
  srcIdx_e               grantIdx_s;
  srcIdx_e               prioPtr_r;
  logic                  grantValid_s;
  logic                  stallNext_s;

  for (genvar g = 0; g < NUMSOURCES; g++) begin : gSrcQueue
    wb_result_fifo #(
      .WIDTH (ENTRYW),
      .DEPTH (FIFODEPTH)
    ) uFifo (
      .clk       (clk),
      .async_rst (async_rst),
      .clk_en    (clk_en),
      .push      (Src_Valid[g]),
      .pushData  ({Src_Data[g], Src_RegAddr[g], Src_Tag[g]}),
      .pop       (popVec_s[g]),
      .headData  (headEntry_s[g]),
      .notFull   (Src_Ready[g]),
      .notEmpty  (nonEmpty_s[g]),
      .countNext (cntNext_s[g])
    );
  end

  // Round-robin pick: first non-empty queue at or above the priority pointer
  always_comb begin
    srcIdx_e cand;
    grantValid_s = 1'b0;
    grantIdx_s   = prioPtr_r;
    cand         = prioPtr_r;
    for (int k = 0; k < NUMSOURCES; k++) begin
      if (!grantValid_s && nonEmpty_s[cand]) begin
        grantValid_s = 1'b1;
        grantIdx_s   = cand;
      end else begin
        grantIdx_s   = grantIdx_s;
      end
      cand = nextSrc(cand);
    end
  end

  // Granted head selection and pop strobe back to its queue
  always_comb begin
    popVec_s = {NUMSOURCES{1'b0}};
    case (grantIdx_s)
      SRC_ALU0:    grantEntry_s = headEntry_s[0];
      SRC_ALU1:    grantEntry_s = headEntry_s[1];
      SRC_COMPLEX: grantEntry_s = headEntry_s[2];
      default:     grantEntry_s = headEntry_s[0];
    endcase
    if (grantValid_s && clk_en) begin
      popVec_s[grantIdx_s] = 1'b1;
    end else begin
      popVec_s = {NUMSOURCES{1'b0}};
    end
  end

  // Congestion looks at post-edge occupancy so the stall lands one cycle later
  always_comb begin
    stallNext_s = 1'b0;
    for (int k = 0; k < NUMSOURCES; k++) begin
      if (cntNext_s[k] >= STALLCNT) begin
        stallNext_s = 1'b1;
      end else begin
        stallNext_s = stallNext_s;
      end
    end
  end

  // Output register, priority pointer and stall flag
  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      prioPtr_r               <= SRC_ALU0;
      RegWriteEn              <= 1'b0;
      RegWriteAddr            <= {REGADDRBITWIDTH{1'b0}};
      RegWriteData            <= {DATABITWIDTH{1'b0}};
      TagClearValid           <= 1'b0;
      TagClearOut             <= {TAGBITWIDTH{1'b0}};
      IssueCongestionStallOut <= 1'b0;
    end else if (clk_en) begin
      IssueCongestionStallOut <= stallNext_s;
      TagClearValid           <= grantValid_s;
      if (grantValid_s) begin
        // Register 0 is a discard target: release the tag but suppress the write
        RegWriteEn   <= (grantEntry_s.regAddr != {REGADDRBITWIDTH{1'b0}});
        RegWriteAddr <= grantEntry_s.regAddr;
        RegWriteData <= grantEntry_s.data;
        TagClearOut  <= grantEntry_s.tag;
        prioPtr_r    <= nextSrc(grantIdx_s);
      end else begin
        RegWriteEn   <= 1'b0;
        prioPtr_r    <= prioPtr_r;
      end
    end else begin
      RegWriteEn    <= 1'b0;
      TagClearValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: vector table plus a queue-based
// reference model feeding a release scoreboard.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int DW    = 16;
  localparam int TW    = 6;
  localparam int AW    = 4;
  localparam int DEPTH = 2;

  logic                clk = 1'b0;
  logic                async_rst;
  logic                clk_en;
  logic [2:0]          Src_Valid;
  logic [2:0]          Src_Ready;
  logic [2:0][DW-1:0]  Src_Data;
  logic [2:0][AW-1:0]  Src_RegAddr;
  logic [2:0][TW-1:0]  Src_Tag;
  logic                RegWriteEn;
  logic [AW-1:0]       RegWriteAddr;
  logic [DW-1:0]       RegWriteData;
  logic                TagClearValid;
  logic [TW-1:0]       TagClearOut;
  logic                IssueCongestionStallOut;

  writeback_arbiter #(
    .DATABITWIDTH(DW), .TAGBITWIDTH(TW), .REGADDRBITWIDTH(AW), .FIFODEPTH(DEPTH)
  ) dut (
    .clk(clk), .async_rst(async_rst), .clk_en(clk_en),
    .Src_Valid(Src_Valid), .Src_Ready(Src_Ready), .Src_Data(Src_Data),
    .Src_RegAddr(Src_RegAddr), .Src_Tag(Src_Tag),
    .RegWriteEn(RegWriteEn), .RegWriteAddr(RegWriteAddr), .RegWriteData(RegWriteData),
    .TagClearValid(TagClearValid), .TagClearOut(TagClearOut),
    .IssueCongestionStallOut(IssueCongestionStallOut)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } entry_t;

  typedef struct {
    int          src;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          expWe;
    logic [TW-1:0] expTag;
    logic [DW-1:0] expData;
  } vec_t;

  entry_t mbuf [3][DEPTH];
  int     mcnt [3];
  int     mptr;
  logic   mstall;
  logic   expPulse;
  entry_t expQ [$];
  entry_t drv  [3];
  vec_t   vecs [5];
  int     nVec = 0;
  int     nMis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
    mptr   = 0;
    mstall = 1'b0;
    expQ.delete();
  endtask

  task automatic fillDrv(input int base);
    for (int i = 0; i < 3; i++) begin
      drv[i] = '{addr: AW'($urandom), data: DW'($urandom), tag: TW'(base * 3 + i)};
    end
  endtask

  // One clock: drive at negedge, predict the edge, compare at the next negedge.
  task automatic step(input logic [2:0] v, input logic en);
    logic [2:0] rdy;
    int         g;
    entry_t     got;
    for (int i = 0; i < 3; i++) begin
      Src_Data[i]    = drv[i].data;
      Src_RegAddr[i] = drv[i].addr;
      Src_Tag[i]     = drv[i].tag;
    end
    Src_Valid = v;
    clk_en    = en;
    #1;
    for (int i = 0; i < 3; i++) rdy[i] = (mcnt[i] < DEPTH);
    chk("src_ready", 32'(Src_Ready), 32'(rdy));
    expPulse = 1'b0;
    if (en) begin
      g = -1;
      for (int k = 0; k < 3; k++) begin
        int c;
        c = (mptr + k) % 3;
        if (g < 0 && mcnt[c] > 0) g = c;
      end
      if (g >= 0) begin
        expQ.push_back(mbuf[g][0]);
        for (int j = 0; j < DEPTH - 1; j++) mbuf[g][j] = mbuf[g][j+1];
        mcnt[g]--;
        mptr     = (g + 1) % 3;
        expPulse = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        if (v[i] && rdy[i]) begin
          mbuf[i][mcnt[i]] = drv[i];
          mcnt[i]++;
        end
      end
      mstall = 1'b0;
      for (int i = 0; i < 3; i++) if (mcnt[i] >= DEPTH - 1) mstall = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("tag_clear_valid", 32'(TagClearValid), 32'(expPulse));
    chk("stall", 32'(IssueCongestionStallOut), 32'(mstall));
    if (TagClearValid) begin
      if (expQ.size() == 0) begin
        nVec++;
        nMis++;
        $display("FAIL unexpected_release: got tag 0x%0h, expected no release", TagClearOut);
      end else begin
        got = expQ.pop_front();
        chk("release_tag", 32'(TagClearOut), 32'(got.tag));
        chk("write_addr", 32'(RegWriteAddr), 32'(got.addr));
        chk("write_data", 32'(RegWriteData), 32'(got.data));
        chk("write_en", 32'(RegWriteEn), 32'(got.addr != '0));
      end
    end else begin
      chk("write_en_idle", 32'(RegWriteEn), 32'd0);
    end
  endtask

  initial begin
    async_rst   = 1'b1;
    clk_en      = 1'b0;
    Src_Valid   = 3'b000;
    Src_Data    = '0;
    Src_RegAddr = '0;
    Src_Tag     = '0;
    for (int i = 0; i < 3; i++) drv[i] = '0;
    modelReset();

    vecs[0] = '{src: 0, addr: 4'd5,  data: 16'h1234, tag: 6'd9,  expWe: 1'b1, expTag: 6'd9,  expData: 16'h1234};
    vecs[1] = '{src: 0, addr: 4'd0,  data: 16'hBEEF, tag: 6'd3,  expWe: 1'b0, expTag: 6'd3,  expData: 16'hBEEF};
    vecs[2] = '{src: 1, addr: 4'd15, data: 16'h0001, tag: 6'd63, expWe: 1'b1, expTag: 6'd63, expData: 16'h0001};
    vecs[3] = '{src: 2, addr: 4'd1,  data: 16'hFFFF, tag: 6'd0,  expWe: 1'b1, expTag: 6'd0,  expData: 16'hFFFF};
    vecs[4] = '{src: 2, addr: 4'd0,  data: 16'h5A5A, tag: 6'd42, expWe: 1'b0, expTag: 6'd42, expData: 16'h5A5A};

    repeat (2) @(negedge clk);
    chk("rst_write_en", 32'(RegWriteEn), 32'd0);
    chk("rst_tag_valid", 32'(TagClearValid), 32'd0);
    chk("rst_stall", 32'(IssueCongestionStallOut), 32'd0);
    chk("rst_tag_out", 32'(TagClearOut), 32'd0);
    chk("rst_ready", 32'(Src_Ready), 32'h7);
    async_rst = 1'b0;

    // Single results: pulse appears in the cycle after the second edge, then holds
    for (int n = 0; n < 5; n++) begin
      drv[vecs[n].src] = '{addr: vecs[n].addr, data: vecs[n].data, tag: vecs[n].tag};
      step(3'(1 << vecs[n].src), 1'b1);
      chk("vec_early", 32'(TagClearValid), 32'd0);
      step(3'b000, 1'b1);
      chk("vec_valid", 32'(TagClearValid), 32'd1);
      chk("vec_tag", 32'(TagClearOut), 32'(vecs[n].expTag));
      chk("vec_we", 32'(RegWriteEn), 32'(vecs[n].expWe));
      chk("vec_data", 32'(RegWriteData), 32'(vecs[n].expData));
      step(3'b000, 1'b1);
      chk("vec_pulse_end", 32'(TagClearValid), 32'd0);
      chk("vec_hold_tag", 32'(TagClearOut), 32'(vecs[n].expTag));
    end

    // Re-align the rotation at ALU0 through a reset, then check 0,1,2 order
    async_rst = 1'b1;
    modelReset();
    @(negedge clk);
    async_rst = 1'b0;
    drv[0] = '{addr: 4'd1, data: 16'h0A0A, tag: 6'd10};
    drv[1] = '{addr: 4'd2, data: 16'h0B0B, tag: 6'd11};
    drv[2] = '{addr: 4'd3, data: 16'h0C0C, tag: 6'd12};
    step(3'b111, 1'b1);
    step(3'b000, 1'b1);
    chk("rr_first", 32'(TagClearOut), 32'd10);
    step(3'b000, 1'b1);
    chk("rr_second", 32'(TagClearOut), 32'd11);
    step(3'b000, 1'b1);
    chk("rr_third", 32'(TagClearOut), 32'd12);
    drv[0] = '{addr: 4'd4, data: 16'h1111, tag: 6'd20};
    drv[2] = '{addr: 4'd6, data: 16'h2222, tag: 6'd22};
    step(3'b101, 1'b1);
    step(3'b000, 1'b1);
    chk("rr_ptr_back_to_0", 32'(TagClearOut), 32'd20);
    step(3'b000, 1'b1);
    chk("rr_then_2", 32'(TagClearOut), 32'd22);

    // ALU1 fills while ALU0 wins the only grant
    fillDrv(1);
    step(3'b111, 1'b1);
    fillDrv(2);
    step(3'b111, 1'b1);
    chk("fill_ready1_low", 32'(Src_Ready[1]), 32'd0);
    chk("fill_stall_high", 32'(IssueCongestionStallOut), 32'd1);
    repeat (5) step(3'b000, 1'b1);
    chk("fill_stall_drop", 32'(IssueCongestionStallOut), 32'd0);
    chk("fill_ready_back", 32'(Src_Ready), 32'h7);

    // Clock enable low with busy queues freezes everything
    for (int n = 0; n < 4; n++) begin
      fillDrv(4 + n);
      step(3'b111, 1'b1);
    end
    fillDrv(9);
    repeat (3) step(3'b111, 1'b0);
    repeat (8) step(3'b000, 1'b1);

    // Reset with entries queued: immediate clear, nothing released afterwards
    fillDrv(11);
    step(3'b111, 1'b1);
    step(3'b000, 1'b1);
    async_rst = 1'b1;
    #1;
    chk("midrst_tag_valid", 32'(TagClearValid), 32'd0);
    chk("midrst_write_en", 32'(RegWriteEn), 32'd0);
    chk("midrst_tag_out", 32'(TagClearOut), 32'd0);
    chk("midrst_addr", 32'(RegWriteAddr), 32'd0);
    chk("midrst_stall", 32'(IssueCongestionStallOut), 32'd0);
    chk("midrst_ready", 32'(Src_Ready), 32'h7);
    modelReset();
    @(negedge clk);
    async_rst = 1'b0;
    repeat (4) step(3'b000, 1'b1);

    // Random traffic against the model, then drain
    for (int n = 0; n < 40; n++) begin
      fillDrv(12 + n);
      step(3'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0));
    end
    repeat (10) step(3'b000, 1'b1);
    chk("scoreboard_drained", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
